d_e_reg: RTL

Decode/execute pipeline register for the five-stage MIPS core: captures the decoded instruction, its forwarded register operands, extended immediate and E-stage control word at each rising edge, and presents them to the E stage (ALU operand muxes, ALU opcode, forwarding/hazard unit). It implements bubble insertion for load-use and other stalls, hazard-timing bookkeeping (Tnew), and a saturating bubble counter for performance inspection.

---
 rtl/d_e_reg.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/d_e_reg.sv
// ---------------------------------------------------------------------------
// d_e_reg : decode/execute pipeline register for the five-stage MIPS core.
//
// Captures the decoded instruction, its forwarded operands, the extended
// immediate and the E-stage control word on every rising clock edge. It also
// tracks E-relative hazard timing (Tnew) and counts inserted bubbles.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   E_clr             insert a bubble this edge (wins over E_en)
//   E_en              load enable; hold when low
//   D_*               decode-stage fields to be captured
//   E_*               registered execute-stage copies
//   M_Tnew_nxt        combinational E_Tnew - 1 (floor 0) for the E/M register
//   E_valid           1 = real instruction, 0 = bubble or reset
//   bubble_cnt        saturating count of bubbles since reset
// ---------------------------------------------------------------------------
module d_e_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_clr,
  input  logic        E_en,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_Instr,
  input  logic [31:0] D_RD1,
  input  logic [31:0] D_RD2,
  input  logic [31:0] D_EXT,
  input  logic [2:0]  D_ALUOp,
  input  logic        D_ALUSrc,
  input  logic        D_RegWrite,
  input  logic [4:0]  D_A3,
  input  logic [1:0]  D_WDSel,
  input  logic        D_MemWrite,
  input  logic [1:0]  D_Tnew,
  output logic [31:0] E_PC,
  output logic [31:0] E_Instr,
  output logic [31:0] E_RD1,
  output logic [31:0] E_RD2,
  output logic [31:0] E_EXT,
  output logic [2:0]  E_ALUOp,
  output logic        E_ALUSrc,
  output logic        E_RegWrite,
  output logic [4:0]  E_A3,
  output logic [1:0]  E_WDSel,
  output logic        E_MemWrite,
  output logic [1:0]  E_Tnew,
  output logic [1:0]  M_Tnew_nxt,
  output logic        E_valid,
  output logic [15:0] bubble_cnt
);

  // Tnew counts down one per stage advance and never goes below zero.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    if (t == 2'd0) begin
      return 2'd0;
    end else begin
      return t - 2'd1;
    end
  endfunction

  logic [31:0] e_pc_q,       e_pc_d;
  logic [31:0] e_instr_q,    e_instr_d;
  logic [31:0] e_rd1_q,      e_rd1_d;
  logic [31:0] e_rd2_q,      e_rd2_d;
  logic [31:0] e_ext_q,      e_ext_d;
  logic [2:0]  e_aluop_q,    e_aluop_d;
  logic        e_alusrc_q,   e_alusrc_d;
  logic        e_regwrite_q, e_regwrite_d;
  logic [4:0]  e_a3_q,       e_a3_d;
  logic [1:0]  e_wdsel_q,    e_wdsel_d;
  logic        e_memwrite_q, e_memwrite_d;
  logic [1:0]  e_tnew_q,     e_tnew_d;
  logic        e_valid_q,    e_valid_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Next-state selection: reset > clear (bubble) > load > hold.
  always_comb begin
    e_pc_d       = e_pc_q;
    e_instr_d    = e_instr_q;
    e_rd1_d      = e_rd1_q;
    e_rd2_d      = e_rd2_q;
    e_ext_d      = e_ext_q;
    e_aluop_d    = e_aluop_q;
    e_alusrc_d   = e_alusrc_q;
    e_regwrite_d = e_regwrite_q;
    e_a3_d       = e_a3_q;
    e_wdsel_d    = e_wdsel_q;
    e_memwrite_d = e_memwrite_q;
    e_tnew_d     = e_tnew_q;
    e_valid_d    = e_valid_q;
    bubble_cnt_d = bubble_cnt_q;

    if (reset || E_clr) begin
      // A bubble is indistinguishable from the reset state (sll $0,$0,0).
      e_pc_d       = RESET_PC;
      e_instr_d    = 32'h0000_0000;
      e_rd1_d      = 32'h0000_0000;
      e_rd2_d      = 32'h0000_0000;
      e_ext_d      = 32'h0000_0000;
      e_aluop_d    = 3'd0;
      e_alusrc_d   = 1'b0;
      e_regwrite_d = 1'b0;
      e_a3_d       = 5'd0;
      e_wdsel_d    = 2'd0;
      e_memwrite_d = 1'b0;
      e_tnew_d     = 2'd0;
      e_valid_d    = 1'b0;
      if (reset) begin
        bubble_cnt_d = 16'h0000;
      end else if (bubble_cnt_q != 16'hFFFF) begin
        bubble_cnt_d = bubble_cnt_q + 16'h0001;
      end else begin
        bubble_cnt_d = bubble_cnt_q;
      end
    end else if (E_en) begin
      e_pc_d       = D_PC;
      e_instr_d    = D_Instr;
      e_rd1_d      = D_RD1;
      e_rd2_d      = D_RD2;
      e_ext_d      = D_EXT;
      e_aluop_d    = D_ALUOp;
      e_alusrc_d   = D_ALUSrc;
      // Writes to $0 are dropped here so forwarding can never match $0.
      e_regwrite_d = D_RegWrite & (D_A3 != 5'd0);
      e_a3_d       = D_A3;
      e_wdsel_d    = D_WDSel;
      e_memwrite_d = D_MemWrite;
      e_tnew_d     = tnew_dec(D_Tnew);
      e_valid_d    = 1'b1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Pipeline register state update.
  always_ff @(posedge clk) begin
    e_pc_q       <= e_pc_d;
    e_instr_q    <= e_instr_d;
    e_rd1_q      <= e_rd1_d;
    e_rd2_q      <= e_rd2_d;
    e_ext_q      <= e_ext_d;
    e_aluop_q    <= e_aluop_d;
    e_alusrc_q   <= e_alusrc_d;
    e_regwrite_q <= e_regwrite_d;
    e_a3_q       <= e_a3_d;
    e_wdsel_q    <= e_wdsel_d;
    e_memwrite_q <= e_memwrite_d;
    e_tnew_q     <= e_tnew_d;
    e_valid_q    <= e_valid_d;
    bubble_cnt_q <= bubble_cnt_d;
  end

  // Output drive; M_Tnew_nxt is the only combinational output.
  always_comb begin
    E_PC       = e_pc_q;
    E_Instr    = e_instr_q;
    E_RD1      = e_rd1_q;
    E_RD2      = e_rd2_q;
    E_EXT      = e_ext_q;
    E_ALUOp    = e_aluop_q;
    E_ALUSrc   = e_alusrc_q;
    E_RegWrite = e_regwrite_q;
    E_A3       = e_a3_q;
    E_WDSel    = e_wdsel_q;
    E_MemWrite = e_memwrite_q;
    E_Tnew     = e_tnew_q;
    M_Tnew_nxt = tnew_dec(e_tnew_q);
    E_valid    = e_valid_q;
    bubble_cnt = bubble_cnt_q;
  end

endmodule
